// File: rtl/wait_time_engine.sv
// wait_time_engine: estimates waiting time as ceil(pcount/tcount) * SVC,
// clipped to the output width. The quotient is found by repeated
// subtraction of the teller count, one subtraction per cycle. A
// start/busy/done handshake connects the block to the queue controller.
module wait_time_engine #(
  parameter int PW  = 4,  // people count width
  parameter int TW  = 2,  // teller count width
  parameter int SVC = 3,  // service time units per customer round
  parameter int OW  = 5   // waiting-time output width
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [PW-1:0] pcount,
  input  logic [TW-1:0] tcount,
  output logic          busy,
  output logic          done,
  output logic [OW-1:0] wtime,
  output logic          sat,
  output logic          err
);

  // Full product width, widened to at least OW so the clip compare is exact.
  localparam int PRW = PW + $clog2(SVC + 1);
  localparam int XW  = (PRW > OW) ? PRW : OW;
  localparam logic [XW-1:0] OMAX = XW'({OW{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rem_q, rem_d;
  logic [TW-1:0]   tlat_q, tlat_d;
  logic [PW-1:0]   rounds_q, rounds_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [OW-1:0]   wtime_q, wtime_d;
  logic            sat_q, sat_d;
  logic            err_q, err_d;
  logic [XW-1:0]   prod;

  function automatic logic [XW-1:0] mul_svc(input logic [PW-1:0] r);
    return XW'(r) * XW'(SVC);
  endfunction

  function automatic logic is_over(input logic [XW-1:0] p);
    return (p > OMAX);
  endfunction

  function automatic logic [OW-1:0] clip(input logic [XW-1:0] p);
    if (is_over(p)) begin
      return {OW{1'b1}};
    end
    return p[OW-1:0];
  endfunction

  // State and datapath registers; reset aborts any computation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      tlat_q   <= '0;
      rounds_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wtime_q  <= '0;
      sat_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      tlat_q   <= tlat_d;
      rounds_q <= rounds_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wtime_q  <= wtime_d;
      sat_q    <= sat_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: latch operands, subtract per cycle, then scale and clip.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    tlat_d   = tlat_q;
    rounds_d = rounds_q;
    done_d   = 1'b0;
    wtime_d  = wtime_q;
    sat_d    = sat_q;
    err_d    = err_q;
    prod     = mul_svc(rounds_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d    = pcount;
          tlat_d   = tcount;
          rounds_d = '0;
          // Nothing to divide: go straight to the result with zero rounds.
          if ((tcount == '0) || (pcount == '0)) begin
            state_d = S_MUL;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        rounds_d = rounds_q + PW'(1);
        // The last partial (or exact) round ends the division.
        if (rem_q <= PW'(tlat_q)) begin
          state_d = S_MUL;
        end else begin
          rem_d = rem_q - PW'(tlat_q);
        end
      end
      S_MUL: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (tlat_q == '0) begin
          wtime_d = '0;
          sat_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          wtime_d = clip(prod);
          sat_d   = is_over(prod);
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy is registered from the next state so it tracks state_q exactly.
    busy_d = (state_d != S_IDLE);
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign wtime = wtime_q;
  assign sat   = sat_q;
  assign err   = err_q;

endmodule

// File: tb/tb_wait_time_engine.sv
// Testbench for wait_time_engine: directed handshake/boundary steps plus
// randomized requests compared against an arithmetic reference model.
module tb_wait_time_engine;

  localparam int PW   = 4;
  localparam int TW   = 2;
  localparam int SVC  = 3;
  localparam int OW   = 5;
  localparam int OMAX = (1 << OW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] pcount;
  logic [TW-1:0] tcount;
  logic          busy;
  logic          done;
  logic [OW-1:0] wtime;
  logic          sat;
  logic          err;

  int tests = 0;
  int fails = 0;

  wait_time_engine #(.PW(PW), .TW(TW), .SVC(SVC), .OW(OW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .pcount (pcount),
    .tcount (tcount),
    .busy   (busy),
    .done   (done),
    .wtime  (wtime),
    .sat    (sat),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: waiting time = rounds * SVC where rounds = ceil(p/t).
  task automatic model(input int p, input int t,
                       output int lat, output int w, output int s, output int e);
    int k;
    int prod;
    if (t == 0) begin
      lat = 1; w = 0; s = 0; e = 1;
    end else if (p == 0) begin
      lat = 1; w = 0; s = 0; e = 0;
    end else begin
      k    = (p + t - 1) / t;
      prod = k * SVC;
      lat  = k + 1;
      w    = (prod > OMAX) ? OMAX : prod;
      s    = (prod > OMAX) ? 1 : 0;
      e    = 0;
    end
  endtask

  // Present a request for one cycle; returns just after the sampling edge.
  task automatic issue(input int p, input int t);
    pcount = PW'(p);
    tcount = TW'(t);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Wait for done, counting edges since the start edge; busy must hold
  // high until the done cycle.
  task automatic wait_done(input string tag, input int already, input int lat,
                           input int w, input int s, input int e);
    int edges;
    bit busy_ok;
    bit got;
    edges   = already;
    busy_ok = 1'b1;
    got     = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_lat"}, edges, lat);
      chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_wtime"}, 32'(wtime), w);
      chk({tag, "_sat"}, 32'(sat), s);
      chk({tag, "_err"}, 32'(err), e);
    end
  endtask

  initial begin
    int lat, w, s, e, p, t;
    bit idle_ok;
    bit saw_done;

    rst_n  = 1'b1;
    start  = 1'b0;
    pcount = '0;
    tcount = '0;

    // Asynchronous reset mid-cycle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wtime", 32'(wtime), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle for 10 cycles with start low.
    idle_ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if ((busy !== 1'b0) || (done !== 1'b0)) idle_ok = 1'b0;
    end
    chk("idle_quiet", 32'(idle_ok), 1);

    // Normal case: 5 people, 2 tellers.
    issue(5, 2);
    wait_done("norm", 0, 4, 9, 0, 0);
    @(posedge clk);
    #1;
    chk("norm_done_clear", 32'(done), 0);
    chk("norm_hold", 32'(wtime), 9);

    // Saturation.
    issue(15, 1);
    wait_done("satur", 0, 16, OMAX, 1, 0);

    // Boundary operands.
    issue(0, 3);
    wait_done("p0", 0, 1, 0, 0, 0);
    issue(7, 0);
    wait_done("t0", 0, 1, 0, 0, 1);

    // Handshake: start while busy is ignored.
    issue(6, 3);
    chk("hs_busy", 32'(busy), 1);
    pcount = PW'(1);
    tcount = TW'(3);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    wait_done("hs1", 1, 3, 6, 0, 0);
    // Start in the done cycle is accepted without a dead cycle.
    issue(7, 3);
    wait_done("hs2", 0, 4, 9, 0, 0);

    // Abort mid-division.
    issue(12, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("ab_wtime", 32'(wtime), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    chk("ab_nodone", 32'(saw_done), 0);
    chk("ab_wtime_after", 32'(wtime), 0);
    issue(2, 2);
    wait_done("ab_next", 0, 2, 3, 0, 0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(0, (1 << PW) - 1));
      t = int'($urandom_range(0, (1 << TW) - 1));
      model(p, t, lat, w, s, e);
      issue(p, t);
      wait_done($sformatf("rnd%0d_p%0d_t%0d", i, p, t), 0, lat, w, s, e);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wait_time_engine.md
# wait_time_engine

Sequential, parametrised waiting-time estimator for the queue-management datapath. It replaces the fixed 2-teller/3-teller lookup with a computed result: wtime = ceil(pcount / tcount) × SVC, saturated to the output width. The division uses iterative subtraction, and a start/busy/done handshake connects the block to the queue controller. The result feeds the display/announcement logic in the same place the ROM output did.

## Interface
Parameters:
- PW, 4: width of the people count.
- TW, 2: width of the teller count.
- SVC, 3: service time units per customer round (constant, ≥1).
- OW, 5: width of the waiting-time output.

Ports:
- clk, input, 1: the single clock; all state changes on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: request a computation; sampled only when busy=0.
- pcount, input, PW: number of people waiting; sampled with start.
- tcount, input, TW: number of open tellers; sampled with start.
- busy, output, 1: high while a computation is in progress (state ≠ IDLE).
- done, output, 1: one-cycle pulse when wtime, sat and err are updated.
- wtime, output, OW: waiting time, saturated to 2^OW−1.
- sat, output, 1: the last result was clipped.
- err, output, 1: the last request had tcount=0.

## Operation
States are IDLE, DIV and MUL. Internal registers are rem (PW bits), tlat (TW bits) and rounds (PW bits).
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, wtime=0, sat=0, err=0.
  - rem=0, rounds=0.
- IDLE with start=1:
  - Latch rem←pcount, tlat←tcount, rounds←0.
  - If tcount=0 or pcount=0, go to MUL (rounds stays 0). Otherwise go to DIV.
  - start=0 leaves the state unchanged.
- DIV, every cycle:
  - rounds←rounds+1.
  - If rem ≤ tlat (tlat zero-extended), go to MUL. Otherwise rem←rem−tlat and stay in DIV.
  - DIV therefore lasts exactly ceil(pcount/tcount) cycles.
- MUL, one cycle:
  - Compute prod = rounds × SVC at full width (PW + clog2(SVC+1) bits).
  - wtime←min(prod, 2^OW−1).
  - sat←(prod > 2^OW−1).
  - err←(tlat=0).
  - done←1; state←IDLE.
  - When err=1, wtime=0 and sat=0.
- done is high for exactly the one cycle after the MUL edge; it is cleared on the next edge.
- wtime, sat and err hold their values until the next done.
- start while busy=1 is ignored; the latched operands are not disturbed.
- start in the cycle done=1 is accepted: the state is already IDLE, so back-to-back requests have no dead cycle.
- Reset mid-operation aborts immediately. No done is produced and the outputs return to their reset values.

## Timing
- busy is a registered decode of state. It rises in the cycle after the start edge and falls in the same cycle done rises.
- Let E0 be the edge that samples start=1, and k = ceil(pcount/tcount).
  - Normal case (pcount>0, tcount>0): done is visible after edge E(k+1), i.e. latency k+1 cycles.
  - pcount=0 or tcount=0: done is visible after E1, i.e. latency 1 cycle.
- Worst-case latency is 2^PW cycles (pcount=2^PW−1, tcount=1).
- No combinational path from inputs to outputs.

## Test plan
- Reset then idle: assert rst_n=0 mid-cycle.
  - Required: all outputs 0 immediately (asynchronous).
  - Required: after release with start=0 for 10 cycles, busy=0 and done=0 throughout.
- Normal case: pcount=5, tcount=2, start for 1 cycle.
  - Required: busy high for 4 cycles.
  - Required: done pulses 4 cycles after E0 with wtime=9, sat=0, err=0.
- Saturation: pcount=15, tcount=1.
  - Required: done after 16 cycles, wtime=31, sat=1.
- Boundary operands:
  - pcount=0, tcount=3 → done after 1 cycle, wtime=0, err=0.
  - pcount=7, tcount=0 → done after 1 cycle, wtime=0, err=1.
- Handshake:
  - Request pcount=6, tcount=3 (wtime=6). Pulse start with pcount=1 while busy=1.
    - Required: the in-flight result is still 6.
  - Assert start with pcount=7, tcount=3 in the done cycle.
    - Required: accepted; done 4 cycles later, wtime=9.
- Abort: pcount=12, tcount=1; drop rst_n at DIV cycle 5.
  - Required: no done pulse and wtime=0.
  - Required: a subsequent request with pcount=2, tcount=2 gives wtime=3.
